// File: rtl/jstk_pkg.sv
// Shared constants, FSM encoding and frame packing for the PmodJSTK SPI responder.
package jstk_pkg;

    localparam logic [6:0] JSTK_CMD_LED_PREFIX = 7'b1000000;
    localparam logic [7:0] JSTK_CMD_CAL        = 8'hA4;
    localparam int         JSTK_FRAME_BYTES    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } jstk_state_e;

    // Five-byte reply: X low, X high, Y low, Y high, buttons.
    function automatic logic [39:0] jstk_build_frame(input logic [9:0] x,
                                                     input logic [9:0] y,
                                                     input logic [2:0] btn);
        return {x[7:0], 6'b000000, x[9:8], y[7:0], 6'b000000, y[9:8], 5'b00000, btn};
    endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between the joystick master and the responder.
interface jstk_spi_responder_if;
    logic SCLK;
    logic chip_select;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output chip_select, output MOSI, input MISO);
    modport slave  (input SCLK, input chip_select, input MOSI, output MISO);
endinterface

// File: rtl/jstk_spi_responder_edge_sync.sv
// Multi-flop synchroniser for SPI pins; the low EDGE_BITS lanes also get rise/fall
// detection, the remaining lanes are plain data.
module spi_edge_sync #(
    parameter int               SYNC_STAGES = 2,
    parameter int               WIDTH       = 3,
    parameter int               EDGE_BITS   = 2,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [WIDTH-1:0]           din_s,
    output logic [WIDTH-EDGE_BITS-1:0] data_s,
    output logic [EDGE_BITS-1:0]       rise_s,
    output logic [EDGE_BITS-1:0]       fall_s
);

    logic [WIDTH-1:0]     sync_r [SYNC_STAGES];
    logic [EDGE_BITS-1:0] hist_r;

    // Synchroniser chain plus one history stage for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= RST_VAL;
            end
            hist_r <= RST_VAL[EDGE_BITS-1:0];
        end else begin
            sync_r[0] <= din_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            hist_r <= sync_r[SYNC_STAGES-1][EDGE_BITS-1:0];
        end
    end

    assign data_s = sync_r[SYNC_STAGES-1][WIDTH-1:EDGE_BITS];
    assign rise_s = sync_r[SYNC_STAGES-1][EDGE_BITS-1:0] & ~hist_r;
    assign fall_s = ~sync_r[SYNC_STAGES-1][EDGE_BITS-1:0] & hist_r;

endmodule

// File: rtl/jstk_spi_responder.sv
// PmodJSTK emulator: SPI mode-0 slave returning X/Y/buttons and decoding LED/calibrate
// commands. Optional FRAME_ERR output enabled by JSTK_RESP_FRAME_ERR_EN.
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BYTES   = JSTK_FRAME_BYTES
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    jstk_spi_responder_if.slave  spi,
    input  logic [9:0]           X_POS,
    input  logic [9:0]           Y_POS,
    input  logic [2:0]           BTN,
    output logic [1:0]           LED_OUT,
    output logic                 CAL_PULSE,
    output logic                 FRAME_DONE,
`ifdef JSTK_RESP_FRAME_ERR_EN
    output logic                 FRAME_ERR,
`endif
    output logic [7:0]           CMD_BYTE
);

    localparam int              BYTE_W    = $clog2(NUM_BYTES + 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES);

    logic              mosi_s;
    logic [1:0]        rise_s;
    logic [1:0]        fall_s;
    logic              sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

    jstk_state_e       state_r, state_next_s;
    logic              load_s, shift_s, finish_s, abort_s;

    logic [39:0]       frame_s;
    logic [38:0]       tx_r;
    logic [6:0]        rx_r;
    logic [7:0]        cmd_tmp_r;
    logic [2:0]        bit_cnt_r;
    logic [BYTE_W-1:0] byte_cnt_r;
    logic              miso_r;
    logic [1:0]        led_r;
    logic              cal_r;
    logic              frame_done_r;
    logic [7:0]        cmd_byte_r;

    // Lane order {MOSI, chip_select, SCLK}; chip_select idles high.
    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (3),
        .EDGE_BITS   (2),
        .RST_VAL     (3'b010)
    ) u_sync (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .din_s  ({spi.MOSI, spi.chip_select, spi.SCLK}),
        .data_s (mosi_s),
        .rise_s (rise_s),
        .fall_s (fall_s)
    );

    assign sclk_rise_s = rise_s[0];
    assign sclk_fall_s = fall_s[0];
    assign cs_rise_s   = rise_s[1];
    assign cs_fall_s   = fall_s[1];
    assign frame_s     = jstk_build_frame(X_POS, Y_POS, BTN);

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  if (cs_fall_s) state_next_s = ST_LOAD;  else state_next_s = ST_IDLE;
            ST_LOAD:  state_next_s = ST_SHIFT;
            ST_SHIFT: begin
                if (byte_cnt_r == BYTE_LAST) begin
                    state_next_s = ST_DONE;
                end else if (cs_rise_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE:  if (cs_rise_s) state_next_s = ST_IDLE;  else state_next_s = ST_DONE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM control strobes.
    always_comb begin
        load_s   = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            ST_IDLE:  load_s = 1'b0;
            ST_LOAD:  load_s = 1'b1;
            ST_SHIFT: begin
                shift_s = 1'b1;
                abort_s = cs_rise_s && (byte_cnt_r != BYTE_LAST);
            end
            ST_DONE:  finish_s = cs_rise_s;
            default:  load_s = 1'b0;
        endcase
    end

    // Shift datapath: frame snapshot, TX/RX shifting and bit/byte counting.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_r       <= 39'd0;
            rx_r       <= 7'd0;
            cmd_tmp_r  <= 8'h00;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= '0;
            miso_r     <= 1'b0;
        end else if (load_s) begin
            tx_r       <= frame_s[38:0];
            miso_r     <= frame_s[39];
            rx_r       <= 7'd0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= '0;
        end else if (shift_s) begin
            if (sclk_rise_s) begin
                rx_r      <= {rx_r[5:0], mosi_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
                    if (byte_cnt_r == '0) begin
                        cmd_tmp_r <= {rx_r, mosi_s};
                    end
                end
            end
            if (sclk_fall_s) begin
                tx_r   <= {tx_r[37:0], 1'b0};
                miso_r <= tx_r[38];
            end
        end else begin
            miso_r <= 1'b0;
        end
    end

    // Frame completion: publish command byte and decode LED / calibrate.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            led_r        <= 2'b00;
            cal_r        <= 1'b0;
            frame_done_r <= 1'b0;
            cmd_byte_r   <= 8'h00;
        end else begin
            frame_done_r <= finish_s;
            cal_r        <= finish_s && (cmd_tmp_r == JSTK_CMD_CAL);
            if (finish_s) begin
                cmd_byte_r <= cmd_tmp_r;
                // Bits [1:0] carry the LED state, so only the upper prefix bits are matched.
                if (cmd_tmp_r[7:2] == JSTK_CMD_LED_PREFIX[6:1]) begin
                    led_r <= cmd_tmp_r[1:0];
                end
            end
        end
    end

    assign spi.MISO   = miso_r;
    assign LED_OUT    = led_r;
    assign CAL_PULSE  = cal_r;
    assign FRAME_DONE = frame_done_r;
    assign CMD_BYTE   = cmd_byte_r;

`ifdef JSTK_RESP_FRAME_ERR_EN
    logic [2:0] gap_r;
    logic       frame_err_r;
    logic       sclk_edge_s;

    assign sclk_edge_s = sclk_rise_s || sclk_fall_s;

    // Flag aborted frames and SCLK edges closer than 4 CLK cycles; gap_r saturates at 4.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gap_r       <= 3'd4;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= abort_s || (shift_s && sclk_edge_s && (gap_r < 3'd4));
            if (load_s) begin
                gap_r <= 3'd4;
            end else if (sclk_edge_s) begin
                gap_r <= 3'd1;
            end else if (gap_r != 3'd4) begin
                gap_r <= gap_r + 3'd1;
            end
        end
    end

    assign FRAME_ERR = frame_err_r;
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: readout, LED/calibrate commands, abort,
// snapshot and mid-frame reset.
module tb_jstk_spi_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x_pos, y_pos;
    logic [2:0] btn;
    logic [1:0] led_out;
    logic       cal_pulse, frame_done;
    logic [7:0] cmd_byte;
`ifdef JSTK_RESP_FRAME_ERR_EN
    logic       frame_err;
    int         err_cnt;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt, cal_cnt;
    logic [39:0] rx;

    jstk_spi_responder_if bus ();

    jstk_spi_responder dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .spi        (bus),
        .X_POS      (x_pos),
        .Y_POS      (y_pos),
        .BTN        (btn),
        .LED_OUT    (led_out),
        .CAL_PULSE  (cal_pulse),
        .FRAME_DONE (frame_done),
`ifdef JSTK_RESP_FRAME_ERR_EN
        .FRAME_ERR  (frame_err),
`endif
        .CMD_BYTE   (cmd_byte)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One mode-0 bit: MOSI set while SCLK low, MISO sampled just before the rise.
    task automatic xfer_bit(input logic mosi_bit, output logic miso_bit);
        bus.MOSI = mosi_bit;
        repeat (8) @(negedge clk);
        miso_bit = bus.MISO;
        bus.SCLK = 1'b1;
        repeat (8) @(negedge clk);
        bus.SCLK = 1'b0;
    endtask

    // Frame of nbits with cmd as byte0; X_POS switches to chg_x before bit chg_bit.
    task automatic run_frame(input logic [7:0] cmd, input int nbits,
                             input int chg_bit, input logic [9:0] chg_x);
        logic [7:0] cmd_sh;
        logic       b;
        cmd_sh   = cmd;
        rx       = 40'd0;
        done_cnt = 0;
        cal_cnt  = 0;
`ifdef JSTK_RESP_FRAME_ERR_EN
        err_cnt  = 0;
`endif
        bus.chip_select = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) x_pos = chg_x;
            xfer_bit(cmd_sh[7], b);
            cmd_sh = {cmd_sh[6:0], 1'b0};
            rx     = {rx[38:0], b};
        end
        repeat (8) @(negedge clk);
        bus.chip_select = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (frame_done) done_cnt++;
            if (cal_pulse)  cal_cnt++;
`ifdef JSTK_RESP_FRAME_ERR_EN
            if (frame_err)  err_cnt++;
`endif
        end
    endtask

    initial begin
        logic b;
        rst_n           = 1'b0;
        x_pos           = 10'h2A5;
        y_pos           = 10'h13C;
        btn             = 3'b101;
        bus.SCLK        = 1'b0;
        bus.chip_select = 1'b1;
        bus.MOSI        = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_miso", 64'(bus.MISO), 64'd0);
        check_val("rst_led", 64'(led_out), 64'd0);
        check_val("rst_cal", 64'(cal_pulse), 64'd0);
        check_val("rst_done", 64'(frame_done), 64'd0);
        check_val("rst_cmd", 64'(cmd_byte), 64'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Frame readout
        run_frame(8'h80, 40, -1, 10'h000);
        check_val("t1_bytes", 64'(rx), 64'hA5_02_3C_01_05);
        check_val("t1_done", 64'(done_cnt), 64'd1);
        check_val("t1_cal", 64'(cal_cnt), 64'd0);
        check_val("t1_led", 64'(led_out), 64'd0);
        check_val("t1_cmd", 64'(cmd_byte), 64'h80);

        // LED commands
        run_frame(8'h83, 40, -1, 10'h000);
        check_val("t2_led11", 64'(led_out), 64'h3);
        check_val("t2_cmd83", 64'(cmd_byte), 64'h83);
        run_frame(8'h81, 40, -1, 10'h000);
        check_val("t2_led01", 64'(led_out), 64'h1);
        run_frame(8'h82, 40, -1, 10'h000);
        check_val("t2_led10", 64'(led_out), 64'h2);

        // Calibrate leaves LEDs alone
        run_frame(8'hA4, 40, -1, 10'h000);
        check_val("t3_cal", 64'(cal_cnt), 64'd1);
        check_val("t3_led", 64'(led_out), 64'h2);
        check_val("t3_cmd", 64'(cmd_byte), 64'hA4);
        check_val("t3_done", 64'(done_cnt), 64'd1);

        // Abort after 17 SCLK cycles
        run_frame(8'h83, 17, -1, 10'h000);
        check_val("t4_done", 64'(done_cnt), 64'd0);
        check_val("t4_led", 64'(led_out), 64'h2);
        check_val("t4_cmd", 64'(cmd_byte), 64'hA4);
`ifdef JSTK_RESP_FRAME_ERR_EN
        check_val("t4_ferr", 64'(err_cnt), 64'd1);
`endif

        // Snapshot: X changes mid-frame, next frame sees it
        run_frame(8'h00, 40, 4, 10'h3FF);
        check_val("t5_snap", 64'(rx), 64'hA5_02_3C_01_05);
        run_frame(8'h00, 40, -1, 10'h000);
        check_val("t5_next", 64'(rx), 64'hFF_03_3C_01_05);

        // Reset during byte2, MISO carrying a 1 at that point
        bus.chip_select = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 20; i++) xfer_bit(1'b0, b);
        check_val("t6_miso_pre", 64'(bus.MISO), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("t6_miso", 64'(bus.MISO), 64'd0);
        check_val("t6_led", 64'(led_out), 64'd0);
        bus.chip_select = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(8'h81, 40, -1, 10'h000);
        check_val("t6_bytes", 64'(rx), 64'hFF_03_3C_01_05);
        check_val("t6_led01", 64'(led_out), 64'h1);
        check_val("t6_cmd", 64'(cmd_byte), 64'h81);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
